// File: rtl/cpu_run_ctrl.sv
// Reset/run controller for the mipscpu core: stretched CPU reset, clock enable, run modes and cycle counter.
// All outputs are registered; a start/step sampled at edge t takes effect on cpu_ce_o from cycle t+1.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             soft_rst_i,
    input  logic [1:0]       mode_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             stop_i,
    input  logic             halt_req_i,
    input  logic [CNT_W-1:0] run_len_i,
    input  logic             clr_count_i,
    output logic             cpu_rst_o,
    output logic             cpu_ce_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       state_o
);

    localparam int unsigned    HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_IDLE = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             budget_q, budget_d;
    logic             ce_q, ce_d;
    logic             rst_q, busy_q, done_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rem_d    = rem_q;
        budget_d = budget_q;
        ce_d     = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_IDLE, S_HALT: begin
                // halt_req/stop outrank start and step, so a pending halt blocks a restart
                if (!halt_req_i && !stop_i) begin
                    if (start_i && mode_i != 2'd2) begin
                        budget_d = (mode_i == 2'd1);
                        rem_d    = run_len_i;
                        if (mode_i == 2'd1 && run_len_i == '0) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_RUN;
                            ce_d    = 1'b1;
                        end
                    end else if (step_i && mode_i == 2'd2 && state_q == S_IDLE) begin
                        ce_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (halt_req_i || stop_i) begin
                    state_d = S_HALT;
                end else if (budget_q && rem_q == CNT_W'(1)) begin
                    state_d = S_HALT;
                    rem_d   = '0;
                end else begin
                    ce_d = 1'b1;
                    if (budget_q) begin
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
        if (soft_rst_i) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            rem_d    = '0;
            budget_d = 1'b0;
            ce_d     = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ce_q && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clr_count_i || soft_rst_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_HOLD;
            hold_q   <= '0;
            rem_q    <= '0;
            budget_q <= 1'b0;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            rst_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rem_q    <= rem_d;
            budget_q <= budget_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            rst_q    <= (state_d == S_HOLD);
            busy_q   <= (state_d == S_RUN);
            done_q   <= (state_d == S_HALT);
        end
    end

    assign cpu_rst_o     = rst_q;
    assign cpu_ce_o      = ce_q;
    assign cycle_count_o = cnt_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (RESET_CYCLES=2, CNT_W=4); per-cycle expectations queued then popped after each edge.
module tb_cpu_run_ctrl;

    localparam int CW = 4;
    localparam logic [2:0] H = 3'd0, I = 3'd1, R = 3'd2, T = 3'd3;

    logic          clk = 1'b0;
    logic          reset, soft_rst, start, step, stop, halt_req, clr_count;
    logic [1:0]    mode;
    logic [CW-1:0] run_len;
    logic          cpu_rst, cpu_ce, busy, done;
    logic [CW-1:0] cycle_count;
    logic [2:0]    state;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RESET_CYCLES(2), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset), .soft_rst_i(soft_rst), .mode_i(mode),
        .start_i(start), .step_i(step), .stop_i(stop), .halt_req_i(halt_req),
        .run_len_i(run_len), .clr_count_i(clr_count),
        .cpu_rst_o(cpu_rst), .cpu_ce_o(cpu_ce), .cycle_count_o(cycle_count),
        .busy_o(busy), .done_o(done), .state_o(state)
    );

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wire [10:0] obs = {cpu_rst, cpu_ce, cycle_count, busy, done, state};

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s observed rst/ce/cnt/busy/done/state=%b expected=%b", e.tag, obs, e.v);
            end
        end
    endtask

    // Queue the outputs required after the coming edge, then advance one cycle.
    task automatic ck(input string tag, input logic r, input logic ce, input logic [CW-1:0] c,
                      input logic b, input logic d, input logic [2:0] s);
        exp_t e;
        e.tag = tag;
        e.v   = {r, ce, c, b, d, s};
        sb.push_back(e);
        tick();
    endtask

    initial begin
        reset = 0; soft_rst = 0; start = 0; step = 0; stop = 0;
        halt_req = 0; clr_count = 0; mode = 2'd0; run_len = '0;

        // power-on reset and reset stretch
        for (int k = 0; k < 3; k++) ck("reset", 1, 0, 0, 0, 0, H);
        reset = 1;
        ck("hold1", 1, 0, 0, 0, 0, H);
        ck("hold_exit", 0, 0, 0, 0, 0, I);

        // run-N with run_len=5
        mode = 2'd1; run_len = 4'd5; start = 1;
        ck("runN_start", 0, 1, 0, 1, 0, R);
        start = 0;
        for (int k = 1; k <= 4; k++) ck("runN", 0, 1, CW'(k), 1, 0, R);
        ck("runN_end", 0, 0, 5, 0, 1, T);
        ck("runN_halted", 0, 0, 5, 0, 1, T);

        // soft reset re-runs the hold sequence and clears the count
        soft_rst = 1;
        ck("soft_rst", 1, 0, 0, 0, 0, H);
        soft_rst = 0;
        ck("soft_hold", 1, 0, 0, 0, 0, H);
        ck("soft_exit", 0, 0, 0, 0, 0, I);

        // run-N with run_len=0 goes straight to HALT
        mode = 2'd1; run_len = 4'd0; start = 1;
        ck("run0_start", 0, 0, 0, 0, 1, T);
        start = 0;
        ck("run0_after", 0, 0, 0, 0, 1, T);

        soft_rst = 1;
        ck("soft_rst2", 1, 0, 0, 0, 0, H);
        soft_rst = 0;
        tick();
        ck("soft_exit2", 0, 0, 0, 0, 0, I);

        // single-step: start ignored, 3 single steps plus one 2-wide step
        mode = 2'd2; start = 1;
        ck("step_start_ign", 0, 0, 0, 0, 0, I);
        start = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1;
            ck("step_on", 0, 1, CW'(k), 0, 0, I);
            step = 0;
            ck("step_off", 0, 0, CW'(k + 1), 0, 0, I);
        end
        step = 1;
        ck("step_wide1", 0, 1, 3, 0, 0, I);
        ck("step_wide2", 0, 1, 4, 0, 0, I);
        step = 0;
        ck("step_wide_off", 0, 0, 5, 0, 0, I);
        ck("step_total", 0, 0, 5, 0, 0, I);

        // free-run halted by halt_req during the 8th enabled cycle
        clr_count = 1;
        ck("clr_idle", 0, 0, 0, 0, 0, I);
        clr_count = 0;
        mode = 2'd0; start = 1;
        ck("free_start", 0, 1, 0, 1, 0, R);
        start = 0;
        for (int k = 1; k <= 7; k++) ck("free_run", 0, 1, CW'(k), 1, 0, R);
        halt_req = 1;
        ck("halt_req", 0, 0, 8, 0, 1, T);
        start = 1;
        ck("start_blocked", 0, 0, 8, 0, 1, T);
        start = 0; halt_req = 0;

        // same with stop; mode change mid-run must not impose a budget
        clr_count = 1;
        ck("clr_halt", 0, 0, 0, 0, 1, T);
        clr_count = 0;
        mode = 2'd0; start = 1;
        ck("restart", 0, 1, 0, 1, 0, R);
        start = 0; mode = 2'd1; run_len = 4'd1;
        for (int k = 1; k <= 7; k++) ck("free_run2", 0, 1, CW'(k), 1, 0, R);
        stop = 1;
        ck("stop", 0, 0, 8, 0, 1, T);
        stop = 0;

        // global reset mid-run
        clr_count = 1;
        ck("clr_halt2", 0, 0, 0, 0, 1, T);
        clr_count = 0;
        mode = 2'd3; start = 1;
        ck("mode3_start", 0, 1, 0, 1, 0, R);
        start = 0;
        ck("mode3_run", 0, 1, 1, 1, 0, R);
        reset = 0;
        ck("reset_mid_run", 1, 0, 0, 0, 0, H);
        reset = 1;
        ck("rehold", 1, 0, 0, 0, 0, H);
        ck("rehold_exit", 0, 0, 0, 0, 0, I);

        // soft reset mid-run
        mode = 2'd0; start = 1;
        ck("run_b", 0, 1, 0, 1, 0, R);
        start = 0;
        ck("run_b1", 0, 1, 1, 1, 0, R);
        soft_rst = 1;
        ck("soft_mid_run", 1, 0, 0, 0, 0, H);
        soft_rst = 0;
        tick();
        ck("soft_mid_exit", 0, 0, 0, 0, 0, I);

        // saturation at 15, then clear coinciding with an enabled cycle
        start = 1;
        ck("sat_start", 0, 1, 0, 1, 0, R);
        start = 0;
        for (int k = 1; k <= 20; k++) ck("sat", 0, 1, (k > 15) ? 4'd15 : CW'(k), 1, 0, R);
        clr_count = 1;
        ck("clr_running", 0, 1, 0, 1, 0, R);
        clr_count = 0;
        ck("after_clr", 0, 1, 1, 1, 0, R);
        stop = 1;
        ck("final_stop", 0, 0, 2, 0, 1, T);
        stop = 0;

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised reset/run controller for mipscpu. Sits between the top-level clock/reset and the CPU core.
- Generates the CPU reset, stretched for a programmable number of cycles after reset release, plus a clock-enable.
- Provides free-run, run-N-cycles and single-step modes, a saturating executed-cycle counter, and halt-on-request.

Parameters:
RESET_CYCLES, 2, cycles cpu_rst stays high after reset is released (must be >= 1)
CNT_W, 32, width of run_len and cycle_count

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
soft_rst  input  1  pulse: re-enter the reset-hold sequence without global reset
mode  input  2  0 = free-run, 1 = run run_len cycles, 2 = single-step, 3 = reserved (treated as 0)
start  input  1  pulse: begin execution in the selected mode
step  input  1  pulse: in mode 2, enable the CPU for exactly one cycle
stop  input  1  pulse: halt execution
halt_req  input  1  level from CPU (e.g. halt instruction); halts execution
run_len  input  CNT_W  cycle budget for mode 1, sampled on start
clr_count  input  1  clears cycle_count
cpu_rst  output  1  active-high reset to the CPU core
cpu_ce  output  1  CPU clock enable; the CPU advances only when this is 1
cycle_count  output  CNT_W  number of cycles with cpu_ce=1; saturates at all-ones
busy  output  1  high in RUN state
done  output  1  high in HALT state
state  output  3  FSM state encoding, for debug

Behaviour:
- All outputs are registered. Reset (reset==0 at a clock edge) sets: state=HOLD, hold counter=0, cpu_rst=1, cpu_ce=0, cycle_count=0, busy=0, done=0, remaining=0.
- Reset has priority over everything. Applying it mid-run aborts the run immediately at the next edge.
- State encodings: HOLD=0, IDLE=1, RUN=2, HALT=3.
- HOLD:
  - cpu_rst=1, cpu_ce=0. The hold counter increments once per cycle with reset==1.
  - When the counter reaches RESET_CYCLES-1, go to IDLE. cpu_rst falls at the same edge.
  - Result: cpu_rst is high for exactly RESET_CYCLES cycles after the first cycle in which reset==1 is sampled.
- soft_rst (any state, reset==1): next state=HOLD, hold counter=0, cpu_rst=1, cpu_ce=0. cycle_count is cleared. Input priority is soft_rst > halt_req > stop > start/step.
- IDLE, start=1 sampled at edge t:
  - mode 0/3: go to RUN. cpu_ce=1 from cycle t+1.
  - mode 1: remaining=run_len. If run_len==0, go straight to HALT (done=1 at t+1, no cpu_ce pulse). Otherwise go to RUN.
  - mode 2: stay in IDLE. start is ignored.
- IDLE, mode 2, step=1 at edge t: cpu_ce=1 for cycle t+1 only. Holding step high for k cycles gives k enable cycles. step in other modes and other states is ignored.
- RUN:
  - cpu_ce=1 and busy=1.
  - Mode 1: remaining decrements on each enabled cycle. On the enabled cycle where remaining==1, go to HALT. This gives exactly run_len cycles with cpu_ce=1.
  - halt_req or stop sampled high: go to HALT. cpu_ce=0 from the next cycle. The cycle in which the request is sampled still counts if cpu_ce was 1.
- HALT: cpu_ce=0, done=1, busy=0.
  - start restarts as from IDLE. A start sampled in HALT with halt_req still high is ignored.
  - Any non-start exit to IDLE only happens via soft_rst/reset.
- mode is sampled on start. Changes to mode during RUN have no effect until the next start.
- cycle_count increments by 1 on each cycle with cpu_ce=1. At all-ones it holds; there is no wrap.
- clr_count=1 zeroes cycle_count. If clr_count coincides with an enabled cycle, the result is 0.
- cpu_ce is never 1 while cpu_rst is 1.

Test Plan:
- Reset 0 for 3 cycles, then 1; RESET_CYCLES=2 -> cpu_rst=1 for exactly 2 cycles after release, then 0; state=IDLE; cpu_ce=0; cycle_count=0.
- Mode 1, run_len=5, start pulse -> cpu_ce=1 for exactly 5 consecutive cycles starting the cycle after start; done=1 afterwards; cycle_count=5.
- Mode 1, run_len=0, start -> done=1 next cycle; cpu_ce never 1; cycle_count=0.
- Mode 2: three separate step pulses plus a 2-cycle-wide step -> 5 single enable cycles; cycle_count=5; busy stays 0.
- Mode 0 run, halt_req raised after 7 enabled cycles -> cpu_ce drops the next cycle; done=1; cycle_count=8. Repeat with stop -> same result; start with halt_req still high -> ignored.
- Reset (0) and then soft_rst mid-RUN -> outputs return to reset values at the next edge; the hold sequence reruns. With CNT_W=4, free-run 20 cycles -> cycle_count saturates at 15; clr_count -> 0.
